// File: rtl/safety_island_pkg.sv
// Shared types for the safety island boot sequencer: pin-level boot modes and FSM states.
package safety_island_pkg;

  typedef enum logic [1:0] {
    Jtag      = 2'd0,
    Preloaded = 2'd1,
    Serial    = 2'd2,
    Reserved  = 2'd3
  } bootmode_e;

  typedef enum logic [2:0] {
    Sample   = 3'd0,
    WaitJtag = 3'd1,
    WaitLoad = 3'd2,
    Boot     = 3'd3,
    Error    = 3'd4
  } boot_state_e;

  // Width of a saturating counter that must be able to hold the value n (at least one bit).
  function automatic int cnt_width(input int unsigned n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/safety_island_boot_debounce.sv
// Boot-pin debouncer: counts consecutive equal samples and flags the cycle in which the
// StableCycles-th equal sample arrives.
module safety_island_boot_debounce
  import safety_island_pkg::*;
#(
  parameter int unsigned StableCycles = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic [1:0] i_bootmode,
  output logic       o_stable_valid,
  output logic [1:0] o_stable_mode
);

  localparam int CntW = cnt_width(StableCycles);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;
  logic [1:0]      r_prev;

  // An empty count means there is no previous sample yet, so this one counts as the first.
  always_comb begin
    w_cnt_next = r_cnt;
    if (r_cnt == '0 || i_bootmode != r_prev) begin
      w_cnt_next = CntW'(1);
    end else if (r_cnt != CntW'(StableCycles)) begin
      w_cnt_next = r_cnt + CntW'(1);
    end
  end

  assign o_stable_valid = (w_cnt_next == CntW'(StableCycles));
  assign o_stable_mode  = i_bootmode;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt  <= '0;
      r_prev <= '0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_prev <= i_bootmode;
    end
  end

endmodule

// File: rtl/safety_island_boot_ctrl.sv
// Boot sequencer for the safety island core: latches the debounced boot mode and releases
// fetch enable with the right boot address, with optional wait timeouts and soft reboot.
module safety_island_boot_ctrl
  import safety_island_pkg::*;
#(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned StableCycles  = 8,
  parameter int unsigned TimeoutCycles = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           bootmode_i,
  input  logic [AddrWidth-1:0] boot_addr_i,
  input  logic                 jtag_go_i,
  input  logic [AddrWidth-1:0] jtag_addr_i,
  output logic                 load_req_o,
  input  logic                 load_ack_i,
  input  logic                 reboot_i,
  output logic                 fetch_en_o,
  output logic [AddrWidth-1:0] boot_addr_o,
  output logic [1:0]           boot_mode_o,
  output logic [2:0]           boot_state_o,
  output logic                 boot_error_o
);

  localparam int ToW = cnt_width(TimeoutCycles);

  boot_state_e          r_state, w_state_next;
  logic [ToW-1:0]       r_to_cnt, w_to_next;
  logic                 r_fetch_en, w_fetch_en_next;
  logic                 r_load_req, w_load_req_next;
  logic                 r_boot_err, w_boot_err_next;
  logic [1:0]           r_boot_mode, w_boot_mode_next;
  logic [AddrWidth-1:0] r_boot_addr, w_boot_addr_next;
  logic                 w_stable_valid;
  logic [1:0]           w_stable_mode;
  logic                 w_expire;

  safety_island_boot_debounce #(
    .StableCycles(StableCycles)
  ) u_debounce (
    .i_clk         (clk_i),
    .i_rst         (rst_i),
    .i_clr         (reboot_i),
    .i_bootmode    (bootmode_i),
    .o_stable_valid(w_stable_valid),
    .o_stable_mode (w_stable_mode)
  );

  // r_to_cnt holds the number of completed wait cycles, so the last allowed cycle sees T-1.
  assign w_expire = (TimeoutCycles != 0) && (r_to_cnt == ToW'(TimeoutCycles - 1));

  // Loader handshake: load_req_o is held while in WaitLoad; the transfer completes in the
  // cycle where load_req_o and load_ack_i are both high. ack with req low has no effect.
  always_comb begin
    w_state_next     = r_state;
    w_to_next        = r_to_cnt;
    w_fetch_en_next  = r_fetch_en;
    w_load_req_next  = r_load_req;
    w_boot_err_next  = r_boot_err;
    w_boot_mode_next = r_boot_mode;
    w_boot_addr_next = r_boot_addr;
    unique case (r_state)
      Sample: begin
        if (w_stable_valid) begin
          w_boot_mode_next = w_stable_mode;
          w_to_next        = '0;
          case (bootmode_e'(w_stable_mode))
            Preloaded: begin
              w_state_next     = Boot;
              w_boot_addr_next = boot_addr_i;
              w_fetch_en_next  = 1'b1;
            end
            Jtag:   w_state_next = WaitJtag;
            Serial: begin
              w_state_next    = WaitLoad;
              w_load_req_next = 1'b1;
            end
            default: begin
              w_state_next    = Error;
              w_boot_err_next = 1'b1;
            end
          endcase
        end
      end
      WaitJtag: begin
        if (jtag_go_i) begin
          w_state_next     = Boot;
          w_boot_addr_next = jtag_addr_i;
          w_fetch_en_next  = 1'b1;
        end else if (w_expire) begin
          w_state_next    = Error;
          w_boot_err_next = 1'b1;
        end else if (r_to_cnt != '1) begin
          w_to_next = r_to_cnt + ToW'(1);
        end
      end
      WaitLoad: begin
        if (r_load_req && load_ack_i) begin
          w_state_next     = Boot;
          w_boot_addr_next = boot_addr_i;
          w_fetch_en_next  = 1'b1;
          w_load_req_next  = 1'b0;
        end else if (w_expire) begin
          w_state_next    = Error;
          w_boot_err_next = 1'b1;
          w_load_req_next = 1'b0;
        end else if (r_to_cnt != '1) begin
          w_to_next = r_to_cnt + ToW'(1);
        end
      end
      Boot, Error: begin
      end
      default: w_state_next = Sample;
    endcase
    // Reboot wins over any transition this cycle but keeps the last latched mode and address.
    if (reboot_i) begin
      w_state_next     = Sample;
      w_to_next        = '0;
      w_fetch_en_next  = 1'b0;
      w_load_req_next  = 1'b0;
      w_boot_err_next  = 1'b0;
      w_boot_mode_next = r_boot_mode;
      w_boot_addr_next = r_boot_addr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= Sample;
      r_to_cnt    <= '0;
      r_fetch_en  <= 1'b0;
      r_load_req  <= 1'b0;
      r_boot_err  <= 1'b0;
      r_boot_mode <= '0;
      r_boot_addr <= '0;
    end else begin
      r_state     <= w_state_next;
      r_to_cnt    <= w_to_next;
      r_fetch_en  <= w_fetch_en_next;
      r_load_req  <= w_load_req_next;
      r_boot_err  <= w_boot_err_next;
      r_boot_mode <= w_boot_mode_next;
      r_boot_addr <= w_boot_addr_next;
    end
  end

  assign fetch_en_o   = r_fetch_en;
  assign load_req_o   = r_load_req;
  assign boot_error_o = r_boot_err;
  assign boot_mode_o  = r_boot_mode;
  assign boot_addr_o  = r_boot_addr;
  assign boot_state_o = r_state;

endmodule
